// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshakes.
// Stage 1 registers bit and group generate/propagate; stage 2 resolves carries and sums.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  logic             s1_valid;
  logic [WIDTH-1:0] g_r, p_r;
  logic [NG-1:0]    gg_r, gp_r;
  logic             cin_r;

  logic s2_adv, s1_adv, accept;

  logic [WIDTH-1:0] g_c, p_c;
  logic [NG-1:0]    gg_c, gp_c;

  logic [NG:0]      gc;
  logic [WIDTH-1:0] bc;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c, ovf_c;
  logic             c_acc, prod, ci;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Bit and group generate/propagate from the raw operands
  always_comb begin
    g_c  = a & b;
    p_c  = a ^ b;
    gg_c = '0;
    gp_c = '1;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < GROUP; k++) begin
        gg_c[j] = g_c[j*GROUP+k] | (p_c[j*GROUP+k] & gg_c[j]);
        gp_c[j] = gp_c[j] & p_c[j*GROUP+k];
      end
    end
  end

  // Each group carry is a flat sum of products over the registered G/P terms
  always_comb begin
    gc    = '0;
    bc    = '0;
    c_acc = 1'b0;
    prod  = 1'b0;
    ci    = 1'b0;
    gc[0] = cin_r;
    for (int j = 0; j < NG; j++) begin
      c_acc = 1'b0;
      for (int k = 0; k <= j; k++) begin
        prod = gg_r[k];
        for (int m = k + 1; m <= j; m++) begin
          prod = prod & gp_r[m];
        end
        c_acc = c_acc | prod;
      end
      prod = cin_r;
      for (int m = 0; m <= j; m++) begin
        prod = prod & gp_r[m];
      end
      gc[j+1] = c_acc | prod;
    end
    for (int j = 0; j < NG; j++) begin
      ci = gc[j];
      for (int k = 0; k < GROUP; k++) begin
        bc[j*GROUP+k] = ci;
        ci = g_r[j*GROUP+k] | (p_r[j*GROUP+k] & ci);
      end
    end
  end

  assign sum_c  = p_r ^ bc;
  assign cout_c = gc[NG];
  assign ovf_c  = bc[WIDTH-1] ^ cout_c;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s1_valid  <= 1'b0;
      g_r       <= '0;
      p_r       <= '0;
      gg_r      <= '0;
      gp_r      <= '0;
      cin_r     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (accept) begin
        g_r      <= g_c;
        p_r      <= p_c;
        gg_r     <= gg_c;
        gp_r     <= gp_c;
        cin_r    <= cin;
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        sum       <= sum_c;
        cout      <= cout_c;
        ovf       <= ovf_c;
        out_valid <= 1'b1;
      end else if (s2_adv) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
